// File: rtl/caf_pkg.sv
// Shared state encoding and sizing helpers for the caf frequency-step generator.
package caf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_KICK    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } caf_fs_state_t;

  // Slot that receives a zero offset; offsets grow symmetrically away from it.
  function automatic int caf_centre(input int foas);
    return (foas - 1) >> 1;
  endfunction

  // One guard bit above the step width so each add exposes its carry.
  function automatic int caf_acc_width(input int phase_bits);
    return phase_bits + 1;
  endfunction

endpackage

// File: rtl/caf_freq_step_gen_if.sv
// Frequency-step handshake between the step generator (master) and caf (slave).
interface caf_freq_step_gen_if #(
  parameter int phase_bits        = 10,
  parameter int foas_counter_bits = 3
);
  logic                         freq_step_req;
  logic [foas_counter_bits-1:0] freq_step_index;
  logic                         freq_step_advance;
  logic [phase_bits-1:0]        freq_step;
  logic                         freq_step_valid;
  logic                         neg_shift;

  modport master (
    input  freq_step_req, freq_step_index,
    output freq_step_advance, freq_step, freq_step_valid, neg_shift
  );

  modport slave (
    output freq_step_req, freq_step_index,
    input  freq_step_advance, freq_step, freq_step_valid, neg_shift
  );
endinterface

// File: rtl/caf_step_mult.sv
// Iterative add-accumulate multiplier: product = operand * count, one add per cycle.
// CAF_FREQ_STEP_SATURATE_EN defined: overflowing products clamp to all-ones instead of wrapping.
module caf_step_mult
  import caf_pkg::*;
#(
  parameter int phase_bits = 10,
  parameter int count_bits = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [phase_bits-1:0] operand,
  input  logic [count_bits-1:0] count,
  output logic [phase_bits-1:0] product,
  output logic                  overflow,
  output logic                  ready
);
  localparam int ACC_W = caf_acc_width(phase_bits);

  logic [phase_bits-1:0] acc_r, acc_cur_s, acc_nxt_s;
  logic [count_bits-1:0] rem_r, rem_cur_s, rem_nxt_s;
  logic                  ovf_r, ovf_cur_s, ovf_nxt_s;
  logic [ACC_W-1:0]      sum_s;

  // start restarts from zero in the same cycle, so a one-add product is ready immediately
  always_comb begin
    acc_cur_s = start ? {phase_bits{1'b0}} : acc_r;
    rem_cur_s = start ? count : rem_r;
    ovf_cur_s = start ? 1'b0 : ovf_r;
    sum_s     = {1'b0, acc_cur_s} + {1'b0, operand};
    if (rem_cur_s != {count_bits{1'b0}}) begin
      acc_nxt_s = sum_s[phase_bits-1:0];
      ovf_nxt_s = ovf_cur_s | sum_s[phase_bits];
      rem_nxt_s = rem_cur_s - count_bits'(1);
    end else begin
      acc_nxt_s = acc_cur_s;
      ovf_nxt_s = ovf_cur_s;
      rem_nxt_s = rem_cur_s;
    end
  end

  // Accumulator state
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= {phase_bits{1'b0}};
      rem_r <= {count_bits{1'b0}};
      ovf_r <= 1'b0;
    end else begin
      acc_r <= acc_nxt_s;
      rem_r <= rem_nxt_s;
      ovf_r <= ovf_nxt_s;
    end
  end

  assign ready    = (rem_cur_s <= count_bits'(1));
  assign overflow = ovf_nxt_s;
`ifdef CAF_FREQ_STEP_SATURATE_EN
  assign product  = ovf_nxt_s ? {phase_bits{1'b1}} : acc_nxt_s;
`else
  assign product  = acc_nxt_s;
`endif

endmodule

// File: rtl/caf_freq_step_gen.sv
// Sequencer that kicks caf into init and then presents one symmetric offset per FOA slot.
// Saturation of overflowing offsets is selected by CAF_FREQ_STEP_SATURATE_EN (see caf_step_mult).
module caf_freq_step_gen
  import caf_pkg::*;
#(
  parameter int phase_bits        = 10,
  parameter int foas              = 3,
  parameter int foas_counter_bits = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [phase_bits-1:0] freq_res,
  caf_freq_step_gen_if.master   fs,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);
  localparam logic [foas_counter_bits-1:0] CENTRE_K = foas_counter_bits'(caf_centre(foas));
  localparam logic [foas_counter_bits-1:0] LAST_K   = foas_counter_bits'(foas - 1);

  caf_fs_state_t                state_r;
  logic [foas_counter_bits-1:0] k_r;
  logic [phase_bits-1:0]        res_r;
  logic                         first_r;
  logic                         advance_r, valid_r, neg_r, busy_r, done_r, ovf_r;
  logic [phase_bits-1:0]        step_r;

  logic [foas_counter_bits-1:0] dist_s;
  logic                         present_ok_s, mult_start_s, mult_ovf_s, mult_ready_s;
  logic [phase_bits-1:0]        mult_product_s;

  // Slot distance from centre and the caf-side acceptance condition
  always_comb begin
    dist_s       = (k_r >= CENTRE_K) ? (k_r - CENTRE_K) : (CENTRE_K - k_r);
    present_ok_s = (fs.freq_step_index == k_r) && (fs.freq_step_req || (k_r == LAST_K));
    mult_start_s = (state_r == ST_COMPUTE) && first_r;
  end

  caf_step_mult #(
    .phase_bits (phase_bits),
    .count_bits (foas_counter_bits)
  ) u_mult (
    .clk      (clk),
    .rst      (rst),
    .start    (mult_start_s),
    .operand  (res_r),
    .count    (dist_s),
    .product  (mult_product_s),
    .overflow (mult_ovf_s),
    .ready    (mult_ready_s)
  );

  // Sequencer FSM with registered outputs; pulses default low every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      k_r       <= {foas_counter_bits{1'b0}};
      res_r     <= {phase_bits{1'b0}};
      first_r   <= 1'b0;
      advance_r <= 1'b0;
      valid_r   <= 1'b0;
      neg_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ovf_r     <= 1'b0;
      step_r    <= {phase_bits{1'b0}};
    end else begin
      advance_r <= 1'b0;
      valid_r   <= 1'b0;
      done_r    <= 1'b0;
      first_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            res_r     <= freq_res;
            k_r       <= {foas_counter_bits{1'b0}};
            ovf_r     <= 1'b0;
            advance_r <= 1'b1;
            busy_r    <= 1'b1;
            state_r   <= ST_KICK;
          end
        end
        ST_KICK: begin
          first_r <= 1'b1;
          state_r <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          if (mult_ready_s) begin
            step_r  <= mult_product_s;
            neg_r   <= (k_r < CENTRE_K);
            ovf_r   <= ovf_r | mult_ovf_s;
            state_r <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          // Valid and advance surface in the cycle after caf is seen ready for slot k
          if (present_ok_s) begin
            valid_r <= 1'b1;
            if (k_r < LAST_K) begin
              advance_r <= 1'b1;
              k_r       <= k_r + foas_counter_bits'(1);
              first_r   <= 1'b1;
              state_r   <= ST_COMPUTE;
            end else begin
              state_r <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign fs.freq_step_advance = advance_r;
  assign fs.freq_step_valid   = valid_r;
  assign fs.freq_step         = step_r;
  assign fs.neg_shift         = neg_r;
  assign busy                 = busy_r;
  assign done                 = done_r;
  assign overflow             = ovf_r;

endmodule
